// File: rtl/cdb_arbiter.sv
// cdb_arbiter -- transmit side of the common data bus.
//
// Collects completed results from the functional units (0 = add,
// 1 = multiply, 2 = divide) into one-entry holding registers and broadcasts
// exactly one of them per cycle through a registered cdb_t output. Holding
// registers are selected round-robin so that no unit can starve another.
//
// Ports:
//   clk_i         clock, all state on rising edge
//   rst_i         synchronous active-high reset (dominates flush_i)
//   flush_i       one-cycle recovery flush; drops held and in-flight results
//   fu_valid_i    per-unit result valid
//   fu_ready_o    per-unit accept; depends only on state, flush_i and rst_i
//   fu_rob_idx_i  per-unit ROB index
//   fu_pd_i       per-unit destination physical register
//   fu_rd_i       per-unit destination architectural register
//   fu_rd_v_i     per-unit result value
//   cdb_o         registered broadcast {rob_idx, pd_s, rd_s, rd_v, valid}

package cdb_pkg;

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [5:0]  pd_s;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic        valid;
  } cdb_t;

endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_FU = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic [NUM_FU-1:0]        fu_valid_i,
  output logic [NUM_FU-1:0]        fu_ready_o,
  input  logic [NUM_FU-1:0][5:0]   fu_rob_idx_i,
  input  logic [NUM_FU-1:0][5:0]   fu_pd_i,
  input  logic [NUM_FU-1:0][4:0]   fu_rd_i,
  input  logic [NUM_FU-1:0][31:0]  fu_rd_v_i,
  output cdb_t                     cdb_o
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [5:0]  rob_idx;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [31:0] rd_v;
  } payload_t;

  // Holding registers (payload and valid kept apart so the valid vector can
  // be used directly in the ready and arbitration logic).
  payload_t [NUM_FU-1:0] hold_q, hold_d;
  logic     [NUM_FU-1:0] hold_valid_q, hold_valid_d;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t             cdb_q, cdb_d;

  logic [NUM_FU-1:0] grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  arb_idx;
  logic [NUM_FU-1:0] xfer;
  logic              block_hs;

  // Modulo-NUM_FU increment; NUM_FU need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (32'(p) == NUM_FU - 1) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // Round-robin arbitration over held entries only. The search starts at
  // rr_ptr_q and walks upward, wrapping; the first valid entry wins.
  // --------------------------------------------------------------------------
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = rr_ptr_q;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      if (!grant_any && hold_valid_q[arb_idx]) begin
        grant[arb_idx] = 1'b1;
        grant_any      = 1'b1;
        grant_idx      = arb_idx;
      end
      arb_idx = ptr_inc(arb_idx);
    end
  end

  // --------------------------------------------------------------------------
  // Handshake. A unit may hand over a result when its slot is empty or is
  // being drained this cycle (grant-refill), which lets a lone unit stream
  // one result per cycle. Ready never looks at fu_valid_i.
  // --------------------------------------------------------------------------
  assign block_hs   = rst_i | flush_i;
  assign fu_ready_o = (~hold_valid_q | grant) & {NUM_FU{~block_hs}};
  assign xfer       = fu_valid_i & fu_ready_o;

  // --------------------------------------------------------------------------
  // Next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    rr_ptr_d     = rr_ptr_q;
    cdb_d        = cdb_q;
    cdb_d.valid  = 1'b0;

    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (xfer[i]) begin
        hold_d[i].rob_idx = fu_rob_idx_i[i];
        hold_d[i].pd      = fu_pd_i[i];
        hold_d[i].rd      = fu_rd_i[i];
        hold_d[i].rd_v    = fu_rd_v_i[i];
        hold_valid_d[i]   = 1'b1;
      end else if (grant[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end

    // Non-valid broadcasts keep the last payload on the bus to avoid
    // needless toggling of the wide data lines.
    if (grant_any) begin
      rr_ptr_d      = ptr_inc(grant_idx);
      cdb_d.rob_idx = hold_q[grant_idx].rob_idx;
      cdb_d.pd_s    = hold_q[grant_idx].pd;
      cdb_d.rd_s    = hold_q[grant_idx].rd;
      cdb_d.rd_v    = hold_q[grant_idx].rd_v;
      cdb_d.valid   = 1'b1;
    end

    // Flush discards this cycle's grant entirely: the pointer does not move
    // and the bus payload is not updated. Transfers cannot occur because
    // ready is forced low.
    if (flush_i) begin
      hold_valid_d = '0;
      rr_ptr_d     = rr_ptr_q;
      cdb_d        = cdb_q;
      cdb_d.valid  = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q       <= '0;
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_q        <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_q        <= cdb_d;
    end
  end

  assign cdb_o = cdb_q;

  // --------------------------------------------------------------------------
  // Structural sanity checks.
  // --------------------------------------------------------------------------
  a_grant_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(grant));

  a_grant_held : assert property (@(posedge clk_i) disable iff (rst_i)
    (grant & ~hold_valid_q) == '0);

  a_ready_blocked : assert property (@(posedge clk_i)
    (rst_i || flush_i) |-> (fu_ready_o == '0));

  a_ptr_range : assert property (@(posedge clk_i) disable iff (rst_i)
    32'(rr_ptr_q) < NUM_FU);

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Transmit side of the common data bus. Collects completed results from the functional units (add, multiply, divide) and drives exactly one `cdb_t` broadcast per cycle to the reservation stations, ROB and physical register file. Each unit gets a one-entry holding register with a valid/ready handshake; a round-robin arbiter picks one held result per cycle, and the broadcast comes from a registered output.

## Interface
- `NUM_FU`, default 3: number of functional-unit result ports. Index 0 = add, 1 = multiply, 2 = divide.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: mispredict/recovery flush, synchronous, one cycle.
- `fu_valid`  in  `NUM_FU`: unit i presents a result.
- `fu_ready`  out  `NUM_FU`: the arbiter accepts unit i's result this cycle.
- `fu_rob_idx`  in  `NUM_FU`x6: ROB index of each result.
- `fu_pd`  in  `NUM_FU`x6: destination physical register.
- `fu_rd`  in  `NUM_FU`x5: destination architectural register.
- `fu_rd_v`  in  `NUM_FU`x32: result value.
- `cdb`  out  `cdb_t` (50 bits): broadcast {`rob_idx`, `pd_s`, `rd_s`, `rd_v`, `valid`}.

## Operation
- State:
  - per-unit holding register `hold[i]` = {`valid`, `rob_idx`, `pd`, `rd`, `rd_v`};
  - round-robin pointer `rr_ptr`, ceil(log2 `NUM_FU`) bits;
  - output register `cdb`.
- Handshake:
  - `fu_ready[i] = !hold[i].valid || grant[i]`, and it is forced low when `flush` or `rst` is high.
  - A transfer occurs when `fu_valid[i] && fu_ready[i]` at a clock edge. The payload is loaded into `hold[i]`, and `hold[i].valid` is set to 1.
  - The unit holds its payload stable while `fu_valid` is high and `fu_ready` is low.
- Arbitration (combinational, on held entries only):
  - Search starts at `rr_ptr` and proceeds upward modulo `NUM_FU`. The first i with `hold[i].valid` is granted. At most one grant per cycle.
  - On a grant of i, `rr_ptr` becomes (i+1) mod `NUM_FU` at the next edge. With no grant, `rr_ptr` is unchanged.
  - On a grant of i with no new transfer from unit i in the same cycle, `hold[i].valid` clears. A simultaneous grant and transfer for i refills `hold[i]` with the new payload (valid stays 1).
- Output register update each edge:
  - With a grant: `cdb.valid` = 1, and the other `cdb` fields are copied from the granted `hold` entry.
  - With no grant: `cdb.valid` = 0, and the other `cdb` fields hold their previous values.
  - The CDB has no backpressure; every broadcast completes in its cycle.
- `pd_s`/`rd_s` = 0 results are broadcast unchanged. Filtering them is the consumer's job.
- Flush:
  - At the edge where `flush` = 1, all `hold[i].valid` and `cdb.valid` clear.
  - Grants and transfers in that cycle are discarded.
  - `rr_ptr` is unchanged.
- Reset (dominates `flush`):
  - `hold[i].valid` = 0, `rr_ptr` = 0.
  - `cdb` = all zeros, including `valid` = 0.
  - `fu_ready` reads low while `rst` is high and reads all 1s in the first cycle after `rst` drops.

## Timing
- Latency: a transfer at edge N puts the entry in `hold` during cycle N..N+1, grants it in that cycle if it wins arbitration, and shows it on `cdb` from edge N+1 for exactly one cycle.
  - Minimum: handshake edge to visible broadcast = 1 edge.
  - Handshake cycle to broadcast cycle = 2 cycles.
- Throughput:
  - 1 broadcast per cycle total.
  - A lone active unit sustains 1 result/cycle, because `fu_ready` stays high via grant-refill.
  - Under full contention each unit gets 1 grant per `NUM_FU` cycles, and its wait is bounded by `NUM_FU`-1 cycles after entering `hold`.
- `fu_ready` combinationally depends only on registered state plus `flush`/`rst`, never on `fu_valid`.

## Test plan
- **Reset values.**
  - Stimulus: assert `rst` 2 cycles with all `fu_valid` = 1.
  - Required: `cdb` = 0 and `fu_ready` = 000 throughout; the first cycle after release gives `fu_ready` = 111 and `cdb.valid` = 0.
- **Single result.**
  - Stimulus: unit 1 sends {`rob_idx`=5, `pd`=33, `rd`=7, `rd_v`=0xDEADBEEF} for one cycle.
  - Required: exactly one cycle of `cdb.valid` = 1 with those fields, 2 cycles after the handshake cycle; `rr_ptr` becomes 2.
- **Contention fairness.**
  - Stimulus: all 3 units hold `fu_valid` = 1 continuously from reset, with ROB tags 10/20/30 incrementing per accepted result.
  - Required: broadcast order unit 0,1,2,0,1,2…; `cdb.valid` is high every cycle; each unit gets `fu_ready` pulses 3 cycles apart.
- **Back-to-back single unit.**
  - Stimulus: unit 2 streams 8 results, other units idle.
  - Required: 8 consecutive `cdb.valid` cycles in order, no bubbles; `fu_ready[2]` stays 1.
- **Flush mid-stream.**
  - Stimulus: all units have held entries and `cdb.valid` = 1; pulse `flush`.
  - Required: the next cycle has `cdb.valid` = 0, all holds are empty, and `fu_ready` was 000 during the flush cycle; no pre-flush result is ever broadcast afterwards.
- **Reset mid-operation.**
  - Stimulus: assert `rst` while under contention, with `rr_ptr` = 2.
  - Required: all state clears; after release with all units valid, unit 0 wins first.
